// File: rtl/pattern_generator.sv
// Triggered test-pattern burst source on a valid/ready stream (inc, dec, Galois LFSR, walking-one).
// Optional last-word flag port last_out is enabled by defining PATGEN_LAST_EN.
module pattern_generator #(
  parameter int          DATA_W      = 32,
  parameter int          LEN_W       = 16,
  parameter logic [31:0] LFSR_TAPS   = 32'h80200003,
  parameter int          DEFAULT_LEN = 2048
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              trigger_in,
  input  logic [1:0]        mode_in,
  input  logic [LEN_W-1:0]  burst_len_in,
  input  logic [DATA_W-1:0] seed_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy_out,
  output logic              done_out
`ifdef PATGEN_LAST_EN
  ,
  output logic              last_out
`endif
);

  localparam int DEF_W = $clog2(DEFAULT_LEN + 1);
  localparam int CNT_W = (LEN_W > DEF_W) ? LEN_W : DEF_W;
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);

  if (DATA_W < 2) begin : g_bad_data_w
    $error("DATA_W must be at least 2");
  end
  if (DEFAULT_LEN < 1 || (64'(DEFAULT_LEN) >> CNT_W) != 64'd0) begin : g_bad_default_len
    $error("DEFAULT_LEN must be in 1 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic              trig_prev;
  logic              trig_edge;
  logic [1:0]        mode_r;
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  eff_len;

  // Galois LFSR shifts right; the feedback mask is applied when the dropped bit is set.
  function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (m)
      2'd0:    r = d + DATA_W'(1);
      2'd1:    r = d - DATA_W'(1);
      2'd2:    r = d[0] ? ((d >> 1) ^ TAPS) : (d >> 1);
      default: r = {d[DATA_W-2:0], d[DATA_W-1]};
    endcase
    return r;
  endfunction

  // A zero seed would freeze the LFSR and give an empty walking-one pattern.
  function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m, input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = s;
    if (s == '0 && m == 2'd2) r = '1;
    if (s == '0 && m == 2'd3) r = DATA_W'(1);
    return r;
  endfunction

  assign trig_edge = trigger_in & ~trig_prev;
  assign eff_len   = (burst_len_in == '0) ? CNT_W'(DEFAULT_LEN) : CNT_W'(burst_len_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      trig_prev <= 1'b0;
      mode_r    <= '0;
      len_r     <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
`ifdef PATGEN_LAST_EN
      last_out  <= 1'b0;
`endif
    end else begin
      trig_prev <= trigger_in;
      done_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_edge) begin
            mode_r    <= mode_in;
            len_r     <= eff_len;
            cnt       <= '0;
            data_out  <= first_word(mode_in, seed_in);
            valid_out <= 1'b1;
            busy_out  <= 1'b1;
            state     <= RUN;
`ifdef PATGEN_LAST_EN
            last_out  <= (eff_len == CNT_W'(1));
`endif
          end
        end
        RUN: begin
          if (valid_out && ready_in) begin
            if (cnt == len_r - CNT_W'(1)) begin
              valid_out <= 1'b0;
              done_out  <= 1'b1;
              state     <= DONE;
`ifdef PATGEN_LAST_EN
              last_out  <= 1'b0;
`endif
            end else begin
              cnt      <= cnt + CNT_W'(1);
              data_out <= next_word(mode_r, data_out);
`ifdef PATGEN_LAST_EN
              last_out <= (cnt + CNT_W'(2) == len_r);
`endif
            end
          end
        end
        DONE: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: directed bursts plus random bursts against a word-list model.
module tb_pattern_generator;
  localparam int          DATA_W      = 32;
  localparam int          LEN_W       = 16;
  localparam int          DEFAULT_LEN = 2048;
  localparam logic [31:0] TAPS        = 32'h80200003;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              trigger_in;
  logic [1:0]        mode_in;
  logic [LEN_W-1:0]  burst_len_in;
  logic [DATA_W-1:0] seed_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;
  logic              busy_out;
  logic              done_out;
`ifdef PATGEN_LAST_EN
  logic              last_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  pattern_generator #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .LFSR_TAPS(TAPS), .DEFAULT_LEN(DEFAULT_LEN)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .trigger_in(trigger_in), .mode_in(mode_in),
    .burst_len_in(burst_len_in), .seed_in(seed_in), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .busy_out(busy_out), .done_out(done_out)
`ifdef PATGEN_LAST_EN
    , .last_out(last_out)
`endif
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word list straight from the pattern definitions.
  function automatic void build_expected(input logic [1:0] m, input logic [31:0] s, input int len);
    logic [31:0] first, w;
    int r;
    exp_q.delete();
    first = s;
    if (s == 32'd0 && m == 2'd2) first = 32'hFFFF_FFFF;
    if (s == 32'd0 && m == 2'd3) first = 32'd1;
    w = first;
    for (int i = 0; i < len; i++) begin
      r = i % 32;
      case (m)
        2'd0: exp_q.push_back(first + 32'(i));
        2'd1: exp_q.push_back(first - 32'(i));
        2'd2: begin
          exp_q.push_back(w);
          w = w[0] ? ((w >> 1) ^ TAPS) : (w >> 1);
        end
        default: exp_q.push_back(r == 0 ? first : ((first << r) | (first >> (32 - r))));
      endcase
    end
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 repeating 1,0,0,1,1
  task automatic run_burst(input logic [1:0] m, input logic [31:0] s, input logic [15:0] l,
                           input int rdy_mode, input bit hold_trig, input bit retrig);
    int len, n, cyc;
    len = (l == 16'd0) ? DEFAULT_LEN : int'(l);
    build_expected(m, s, len);
    mode_in = m; seed_in = s; burst_len_in = l; trigger_in = 1'b1; ready_in = 1'b1;
    @(negedge clk_in);
    chk_bit("first_valid", valid_out, 1'b1);
    chk_bit("first_busy", busy_out, 1'b1);
    mode_in = 2'($urandom); seed_in = $urandom; burst_len_in = 16'($urandom);
    if (!hold_trig) trigger_in = 1'b0;
    n = 0; cyc = 0;
    while (n < len && cyc < 8 * len + 50) begin
      chk_bit("valid_held", valid_out, 1'b1);
      chk_word("data", data_out, exp_q[0]);
      chk_bit("no_early_done", done_out, 1'b0);
`ifdef PATGEN_LAST_EN
      chk_bit("last", last_out, exp_q.size() == 1);
`endif
      case (rdy_mode)
        0:       ready_in = 1'b1;
        1:       ready_in = 1'($urandom_range(0, 1));
        default: ready_in = !((cyc % 5) == 1 || (cyc % 5) == 2);
      endcase
      if (retrig) trigger_in = (n >= 100 && n < 110);
      if (valid_out && ready_in) begin
        void'(exp_q.pop_front());
        n++;
      end
      cyc++;
      @(negedge clk_in);
    end
    chk_word("burst_words", 32'(n), 32'(len));
    chk_bit("end_valid", valid_out, 1'b0);
    chk_bit("done_pulse", done_out, 1'b1);
    chk_bit("done_busy", busy_out, 1'b1);
    @(negedge clk_in);
    chk_bit("done_once", done_out, 1'b0);
    chk_bit("idle_busy", busy_out, 1'b0);
    chk_bit("idle_valid", valid_out, 1'b0);
  endtask

  initial begin
    logic [1:0]  rm;
    logic [31:0] rs;
    rst_in = 1'b1; trigger_in = 1'b0; ready_in = 1'b1;
    mode_in = 2'd0; burst_len_in = '0; seed_in = '0;
    #12;
    chk_bit("rst_valid", valid_out, 1'b0);
    chk_bit("rst_busy", busy_out, 1'b0);
    chk_bit("rst_done", done_out, 1'b0);
    chk_word("rst_data", data_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_bit("idle_no_burst", valid_out, 1'b0);

    // Directed bursts from the pattern definitions
    run_burst(2'd0, 32'hFFFF_FFFE, 16'd4, 0, 1'b0, 1'b0);
    run_burst(2'd1, 32'h0000_0001, 16'd3, 2, 1'b0, 1'b0);
    run_burst(2'd2, 32'h0000_0000, 16'd3, 0, 1'b0, 1'b0);
    run_burst(2'd3, 32'h8000_0000, 16'd2, 0, 1'b0, 1'b0);
    run_burst(2'd3, 32'h0000_0000, 16'd1, 1, 1'b0, 1'b0);
    run_burst(2'd0, 32'h0000_0000, 16'd0, 0, 1'b0, 1'b1);

    // Trigger held high through the end of a burst must not restart it
    run_burst(2'd0, 32'h0000_0010, 16'd3, 0, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk_in);
      chk_bit("held_trig_no_restart", valid_out, 1'b0);
    end
    trigger_in = 1'b0;
    @(negedge clk_in);
    run_burst(2'd1, 32'h0000_0100, 16'd5, 1, 1'b0, 1'b0);

    // Asynchronous reset mid-burst
    mode_in = 2'd0; seed_in = 32'd5; burst_len_in = 16'd10; trigger_in = 1'b1; ready_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk_bit("abort_valid", valid_out, 1'b0);
    chk_bit("abort_busy", busy_out, 1'b0);
    chk_word("abort_data", data_out, 32'd0);
    chk_bit("abort_done", done_out, 1'b0);
    @(negedge clk_in);
    chk_bit("abort_no_done", done_out, 1'b0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_bit("abort_idle", valid_out, 1'b0);
    run_burst(2'd2, 32'h1234_5678, 16'd6, 1, 1'b0, 1'b0);

    // Random bursts
    for (int k = 0; k < 8; k++) begin
      rm = 2'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_burst(rm, rs, 16'($urandom_range(1, 20)), 1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
Parametrised successor to the trigger-driven counter source. On a rising edge of trigger_in it emits one burst of run-time-programmable length on a valid/ready stream. The pattern is selectable per burst: increment, decrement, LFSR or walking-one. The block sits in front of the FIFO/DMA path as a test-data source and, unlike its predecessor, honours downstream backpressure and reports burst completion.

Parameters:
DATA_W, 32, data word width (>= 2)
LEN_W, 16, width of the burst-length input and word counter
LFSR_TAPS, 32'h80200003, Galois feedback mask for mode 2; the low DATA_W bits are used
DEFAULT_LEN, 2048, burst length used when burst_len_in == 0 at trigger

Ports:
clk_in  in  1  system clock; all logic on the rising edge
rst_in  in  1  reset, asynchronous and active-high
trigger_in  in  1  level input; a rising edge requests one burst
mode_in  in  2  pattern select, sampled at trigger: 0 inc, 1 dec, 2 LFSR, 3 walking-one
burst_len_in  in  LEN_W  words per burst, sampled at trigger; 0 selects DEFAULT_LEN
seed_in  in  DATA_W  first word of the burst, sampled at trigger
data_out  out  DATA_W  stream data
valid_out  out  1  stream valid
ready_in  in  1  downstream ready
busy_out  out  1  high while a burst is in progress
done_out  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async assert, released synchronously by the integrator): data_out=0, valid_out=0, busy_out=0, done_out=0, trigger history=0, state=IDLE, counters=0.
- Edge detect: register trig_prev <= trigger_in. edge = trigger_in & ~trig_prev, evaluated combinationally against the registered history. A trigger held high from reset release counts as one edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clock edge where edge=1, latch mode, length and seed.
  - Go to RUN with data_out=first word, valid_out=1, busy_out=1 on that same clock edge, giving 1-cycle latency from trigger sampled high to valid_out high.
- First word:
  - Normally seed_in.
  - Mode 2 with seed 0: use all-ones, since the LFSR must not lock up.
  - Mode 3 with seed 0: use 1.
- RUN, handshake:
  - A transfer occurs on each clock with valid_out & ready_in.
  - While valid_out=1 and ready_in=0, data_out and valid_out hold stable.
  - valid_out never drops mid-burst; there are no gaps while ready_in=1.
- RUN, advance rules on each transfer:
  - Mode 0: data+1, wraps all-ones -> 0.
  - Mode 1: data-1, wraps 0 -> all-ones.
  - Mode 2: Galois step. If lsb=1: (data>>1) ^ LFSR_TAPS[DATA_W-1:0]. Else: data>>1.
  - Mode 3: rotate left by 1; msb wraps to bit 0.
- RUN, word counter: counts transfers from 0. On the transfer where count == len-1: valid_out <= 0, go to DONE.
- DONE: done_out=1 for exactly one cycle; busy_out is still 1 in this cycle. Next cycle: IDLE, busy_out=0.
- Triggers: edges arriving in RUN or DONE are ignored (not queued); trig_prev still tracks. A new burst needs a fresh edge in IDLE.
- Input changes: mode_in, burst_len_in and seed_in changes after the trigger do not affect the running burst.
- Reset mid-burst: immediately aborts. Outputs go to reset values; no done_out pulse.
- Length: burst_len_in = 2^LEN_W-1 gives that many words. The counter is LEN_W bits, plus enough width to hold DEFAULT_LEN; DEFAULT_LEN must fit, checked by an elaboration assertion.

Optional Feature:
PATGEN_LAST_EN
- Defined: adds port last_out (out, 1). last_out=1 exactly when valid_out=1 and the word is the final word of the burst. It is held with data_out under backpressure and is 0 at reset.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Mode 0, seed=0xFFFFFFFE, len=4, ready_in=1 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 on consecutive cycles. valid_out rises 1 cycle after trigger. done_out pulses once, 1 cycle after the last word. busy_out low the cycle after that.
- Mode 1, seed=0x00000001, len=3, ready_in toggling 1,0,0,1,1 -> accepted words 0x1, 0x0, 0xFFFFFFFF. data_out stable during ready_in=0. Exactly 3 transfers.
- Mode 2, seed=0, len=3 -> 0xFFFFFFFF, then 0x7FFFFFFF^0x80200003=0xFFDFFFFC, then 0x7FEFFFFE. Mode 3, seed=0x80000000, len=2 -> 0x80000000, 0x00000001.
- len=0, mode 0, seed=0 -> DEFAULT_LEN words 0..2047, then done_out. A second trigger edge mid-burst is ignored: total still 2048 words and one done_out.
- trigger_in held high across burst end -> no second burst. Drop then raise -> second burst starts 1 cycle after the rise.
- Assert rst_in asynchronously mid-burst (between clock edges) -> valid_out, busy_out and data_out go to 0 immediately; no done_out. A trigger after release starts a clean burst.
